control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Next-generation RV32I main control unit for the 5-stage core.
- Decodes the ID-stage opcode, including the branch and JAL opcodes the first-generation decoder left out.
- Detects load-use hazards, supporting multi-cycle load latency via a parameterised stall counter.
- Owns the ID/EX control-field register, with bubble insertion on stall or flush and freeze on hold, plus a saturating bubble counter for performance monitoring.

Parameters:
- OP_W, 7, opcode width.
- RA_W, 5, register address width.
- ALUOP_W, 2, ALUop field width (values below fit in 2 bits; wider MSBs are zero-filled).
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1).
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ID_valid_i  in  1  IF_ID holds a valid instruction.
- ID_op_i  in  OP_W  IF_ID_instr[6:0].
- ID_rs1_i  in  RA_W  IF_ID_instr[19:15].
- ID_rs2_i  in  RA_W  IF_ID_instr[24:20].
- EX_rd_i  in  RA_W  rd of the instruction currently in ID/EX.
- EX_redirect_i  in  1  branch taken / jump resolved in EX.
- hold_i  in  1  global freeze (memory busy).
- ID_imm_sel_o  out  3  combinational immediate format: 0 I, 1 S, 2 B, 3 J.
- EX_ALUop_o  out  ALUOP_W  registered.
- EX_ALUsrc_o  out  1  registered.
- EX_RegWrite_o  out  1  registered.
- EX_MemRead_o  out  1  registered.
- EX_MemWrite_o  out  1  registered.
- EX_MemToReg_o  out  1  registered.
- EX_Branch_o  out  1  registered.
- EX_Jump_o  out  1  registered.
- EX_illegal_o  out  1  registered; unknown opcode with ID_valid_i.
- stall_o  out  1  combinational; PC and IF_ID write disable.
- flush_o  out  1  combinational; IF_ID flush.
- bubble_cnt_o  out  CNT_W  bubbles inserted, saturating.

Behaviour:

Decode (combinational), with fields ALUop/src/RW/MR/MW/MTR/Br/J/imm:
- 0110011 R: 11/0/1/0/0/0/0/0/I.
- 0010011 I-ALU: 10/1/1/0/0/0/0/0/I.
- 0000011 Load: 01/1/1/1/0/1/0/0/I.
- 0100011 Store: 01/1/0/0/1/0/0/0/S.
- 1100011 Branch: 00/0/0/0/0/0/1/0/B.
- 1101111 JAL: 00/1/1/0/0/0/0/1/J.
- Any other opcode: all zeros, imm I; illegal = ID_valid_i.
- ID_valid_i=0 forces the decode to a bubble.

Bubble and reset:
- Bubble = every EX_* control field 0, EX_illegal_o 0.
- Reset: all EX_* 0, cnt 0, bubble_cnt_o 0; stall_o and flush_o follow their equations from the zeroed state.

Hazard:
- haz = EX_MemRead_o & (EX_rd_i != 0) & ID_valid_i & ((EX_rd_i == ID_rs1_i) | (uses_rs2 & EX_rd_i == ID_rs2_i)).
- uses_rs2 holds for R, Store and Branch only.

Stall counter cnt (width ceil(log2(STALL_CYCLES+1))):
- stall_o = (haz | cnt != 0) & ~EX_redirect_i.
- haz & cnt==0 & ~hold_i: cnt <= STALL_CYCLES-1.
- cnt != 0 & ~hold_i: cnt decrements.

flush_o = EX_redirect_i.

ID/EX update priority per clock edge:
1. EX_redirect_i: load bubble, cnt <= 0, increment bubble count.
2. hold_i: all registers hold, no count.
3. stall_o: load bubble, increment bubble count.
4. Otherwise: load the decode.

Bubble counter and boundaries:
- bubble_cnt_o saturates at 2^CNT_W-1; it never wraps.
- Load-use latency: a load followed by a dependent instruction gives exactly STALL_CYCLES bubbles; the dependent instruction enters EX on cycle STALL_CYCLES+1.
- A redirect during a stall aborts the stall the same cycle.
- Reset mid-stall returns to the idle, unstalled state immediately (asynchronous).
- A hazard against rd = x0 never stalls.

Test Plan:
- Reset, then one of each opcode (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1110011) -> EX fields match the table one cycle later; 1110011 gives EX_illegal_o=1, all else 0; ID_imm_sel_o is 1 for Store, 2 for Branch, 3 for JAL.
- STALL_CYCLES=1: LW x5 then ADD x6,x5,x1 -> stall_o high for 1 cycle, one bubble, ADD decode in EX next cycle, bubble_cnt_o=1. Repeat with STALL_CYCLES=3 -> 3 stall cycles, bubble_cnt_o=3.
- LW x0 followed by a reader of x0; LW x5 followed by I-ALU with rs2 field=5 -> no stall in either case.
- Stall active (cnt=2) with EX_redirect_i pulse -> flush_o=1, stall_o=0, bubble loaded, cnt=0, next instruction decodes normally.
- hold_i=1 for 4 cycles mid-stall -> EX_* and cnt frozen, bubble_cnt_o unchanged; the stall resumes after release.
- CNT_W=2 with 5 forced bubbles -> bubble_cnt_o stops at 3; rst_n_i low asynchronously mid-stall -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/control_pipe.sv
// RV32I main control for the 5-stage core: ID-stage opcode decode, load-use
// hazard detection with a multi-cycle stall counter, and the ID/EX control register.
module control_pipe #(
    parameter int OP_W         = 7,
    parameter int RA_W         = 5,
    parameter int ALUOP_W      = 2,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ID_valid_i,
    input  logic [OP_W-1:0]    ID_op_i,
    input  logic [RA_W-1:0]    ID_rs1_i,
    input  logic [RA_W-1:0]    ID_rs2_i,
    input  logic [RA_W-1:0]    EX_rd_i,
    input  logic               EX_redirect_i,
    input  logic               hold_i,
    output logic [2:0]         ID_imm_sel_o,
    output logic [ALUOP_W-1:0] EX_ALUop_o,
    output logic               EX_ALUsrc_o,
    output logic               EX_RegWrite_o,
    output logic               EX_MemRead_o,
    output logic               EX_MemWrite_o,
    output logic               EX_MemToReg_o,
    output logic               EX_Branch_o,
    output logic               EX_Jump_o,
    output logic               EX_illegal_o,
    output logic               stall_o,
    output logic               flush_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam int SC_W   = $clog2(STALL_CYCLES + 1);
    localparam int CTRL_W = ALUOP_W + 8;

    localparam logic [OP_W-1:0] OPC_R      = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OPC_I      = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OPC_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OPC_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OPC_BRANCH = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OPC_JAL    = OP_W'(7'b1101111);

    localparam logic [SC_W-1:0] SC_RELOAD = SC_W'(STALL_CYCLES - 1);

    logic [1:0]        w_aluop;
    logic              w_src, w_rw, w_mr, w_mw, w_mtr, w_br, w_j, w_ill;
    logic              w_uses_rs2;
    logic [2:0]        w_imm_sel;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_haz;
    logic [CNT_W-1:0]  w_bubble_next;

    logic [CTRL_W-1:0] r_ctrl;
    logic [SC_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    always_comb begin
        w_aluop    = 2'b00;
        w_src      = 1'b0;
        w_rw       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_mtr      = 1'b0;
        w_br       = 1'b0;
        w_j        = 1'b0;
        w_ill      = 1'b0;
        w_uses_rs2 = 1'b0;
        w_imm_sel  = 3'd0;
        case (ID_op_i)
            OPC_R: begin
                w_aluop    = 2'b11;
                w_rw       = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OPC_I: begin
                w_aluop = 2'b10;
                w_src   = 1'b1;
                w_rw    = 1'b1;
            end
            OPC_LOAD: begin
                w_aluop = 2'b01;
                w_src   = 1'b1;
                w_rw    = 1'b1;
                w_mr    = 1'b1;
                w_mtr   = 1'b1;
            end
            OPC_STORE: begin
                w_aluop    = 2'b01;
                w_src      = 1'b1;
                w_mw       = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm_sel  = 3'd1;
            end
            OPC_BRANCH: begin
                w_br       = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm_sel  = 3'd2;
            end
            OPC_JAL: begin
                w_src     = 1'b1;
                w_rw      = 1'b1;
                w_j       = 1'b1;
                w_imm_sel = 3'd3;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // An invalid ID slot decodes to a bubble, including the illegal flag.
    assign w_dec_ctrl = ID_valid_i
                      ? {ALUOP_W'(w_aluop), w_src, w_rw, w_mr, w_mw, w_mtr, w_br, w_j, w_ill}
                      : '0;

    assign w_haz = EX_MemRead_o & (EX_rd_i != '0) & ID_valid_i
                 & ((EX_rd_i == ID_rs1_i) | (w_uses_rs2 & (EX_rd_i == ID_rs2_i)));

    assign stall_o       = (w_haz | (r_cnt != '0)) & ~EX_redirect_i;
    assign flush_o       = EX_redirect_i;
    assign ID_imm_sel_o  = w_imm_sel;
    assign w_bubble_next = (&r_bubble_cnt) ? r_bubble_cnt : r_bubble_cnt + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl       <= '0;
            r_cnt        <= '0;
            r_bubble_cnt <= '0;
        end else if (EX_redirect_i) begin
            r_ctrl       <= '0;
            r_cnt        <= '0;
            r_bubble_cnt <= w_bubble_next;
        end else if (!hold_i) begin
            if (stall_o) begin
                r_ctrl       <= '0;
                r_bubble_cnt <= w_bubble_next;
                // cnt==0 while stalling implies a fresh hazard: arm the remaining bubbles.
                if (r_cnt == '0) begin
                    r_cnt <= SC_RELOAD;
                end else begin
                    r_cnt <= r_cnt - SC_W'(1);
                end
            end else begin
                r_ctrl <= w_dec_ctrl;
            end
        end
    end

    assign EX_ALUop_o    = r_ctrl[CTRL_W-1 -: ALUOP_W];
    assign EX_ALUsrc_o   = r_ctrl[7];
    assign EX_RegWrite_o = r_ctrl[6];
    assign EX_MemRead_o  = r_ctrl[5];
    assign EX_MemWrite_o = r_ctrl[4];
    assign EX_MemToReg_o = r_ctrl[3];
    assign EX_Branch_o   = r_ctrl[2];
    assign EX_Jump_o     = r_ctrl[1];
    assign EX_illegal_o  = r_ctrl[0];
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: three instances (1-cycle stall, 3-cycle stall, 2-bit
// bubble counter) share one stimulus stream; expected EX fields go through queues.
module tb_control_pipe;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_op = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       redirect = 1'b0, hold = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  d1_imm, d3_imm, ds_imm;
    logic [1:0]  d1_aluop, d3_aluop, ds_aluop;
    logic        d1_src, d1_rw, d1_mr, d1_mw, d1_mtr, d1_br, d1_j, d1_ill, d1_stall, d1_flush;
    logic        d3_src, d3_rw, d3_mr, d3_mw, d3_mtr, d3_br, d3_j, d3_ill, d3_stall, d3_flush;
    logic        ds_src, ds_rw, ds_mr, ds_mw, ds_mtr, ds_br, ds_j, ds_ill, ds_stall, ds_flush;
    logic [15:0] d1_cnt, d3_cnt;
    logic [1:0]  ds_cnt;
    logic [9:0]  d1_ex, d3_ex, ds_ex;

    assign d1_ex = {d1_aluop, d1_src, d1_rw, d1_mr, d1_mw, d1_mtr, d1_br, d1_j, d1_ill};
    assign d3_ex = {d3_aluop, d3_src, d3_rw, d3_mr, d3_mw, d3_mtr, d3_br, d3_j, d3_ill};
    assign ds_ex = {ds_aluop, ds_src, ds_rw, ds_mr, ds_mw, ds_mtr, ds_br, ds_j, ds_ill};

    control_pipe #(.STALL_CYCLES(1), .CNT_W(16)) u_d1 (
        .clk_i(clk), .rst_n_i(rst_n), .ID_valid_i(id_valid), .ID_op_i(id_op),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .EX_rd_i(ex_rd),
        .EX_redirect_i(redirect), .hold_i(hold), .ID_imm_sel_o(d1_imm),
        .EX_ALUop_o(d1_aluop), .EX_ALUsrc_o(d1_src), .EX_RegWrite_o(d1_rw),
        .EX_MemRead_o(d1_mr), .EX_MemWrite_o(d1_mw), .EX_MemToReg_o(d1_mtr),
        .EX_Branch_o(d1_br), .EX_Jump_o(d1_j), .EX_illegal_o(d1_ill),
        .stall_o(d1_stall), .flush_o(d1_flush), .bubble_cnt_o(d1_cnt));

    control_pipe #(.STALL_CYCLES(3), .CNT_W(16)) u_d3 (
        .clk_i(clk), .rst_n_i(rst_n), .ID_valid_i(id_valid), .ID_op_i(id_op),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .EX_rd_i(ex_rd),
        .EX_redirect_i(redirect), .hold_i(hold), .ID_imm_sel_o(d3_imm),
        .EX_ALUop_o(d3_aluop), .EX_ALUsrc_o(d3_src), .EX_RegWrite_o(d3_rw),
        .EX_MemRead_o(d3_mr), .EX_MemWrite_o(d3_mw), .EX_MemToReg_o(d3_mtr),
        .EX_Branch_o(d3_br), .EX_Jump_o(d3_j), .EX_illegal_o(d3_ill),
        .stall_o(d3_stall), .flush_o(d3_flush), .bubble_cnt_o(d3_cnt));

    control_pipe #(.STALL_CYCLES(1), .CNT_W(2)) u_ds (
        .clk_i(clk), .rst_n_i(rst_n), .ID_valid_i(id_valid), .ID_op_i(id_op),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .EX_rd_i(ex_rd),
        .EX_redirect_i(redirect), .hold_i(hold), .ID_imm_sel_o(ds_imm),
        .EX_ALUop_o(ds_aluop), .EX_ALUsrc_o(ds_src), .EX_RegWrite_o(ds_rw),
        .EX_MemRead_o(ds_mr), .EX_MemWrite_o(ds_mw), .EX_MemToReg_o(ds_mtr),
        .EX_Branch_o(ds_br), .EX_Jump_o(ds_j), .EX_illegal_o(ds_ill),
        .stall_o(ds_stall), .flush_o(ds_flush), .bubble_cnt_o(ds_cnt));

    int         checks = 0;
    int         failures = 0;
    logic [9:0] q1[$];
    logic [9:0] q3[$];
    logic [9:0] exp_v;

    // Reference control table: {ALUop, src, RW, MR, MW, MTR, Br, J, illegal}.
    function automatic logic [9:0] exp_ctrl(input logic [6:0] op, input logic v);
        logic [9:0] r;
        case (op)
            OP_R:      r = 10'b11_0_1_0_0_0_0_0_0;
            OP_I:      r = 10'b10_1_1_0_0_0_0_0_0;
            OP_LOAD:   r = 10'b01_1_1_1_0_1_0_0_0;
            OP_STORE:  r = 10'b01_1_0_0_1_0_0_0_0;
            OP_BRANCH: r = 10'b00_0_0_0_0_0_1_0_0;
            OP_JAL:    r = 10'b00_1_1_0_0_0_0_1_0;
            default:   r = 10'b00_0_0_0_0_0_0_0_1;
        endcase
        return v ? r : 10'b0;
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            OP_STORE:  return 3'd1;
            OP_BRANCH: return 3'd2;
            OP_JAL:    return 3'd3;
            default:   return 3'd0;
        endcase
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd_ex, input logic v, input logic red, input logic hd);
        id_op = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd_ex;
        id_valid = v; redirect = red; hold = hd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        q1.delete();
        q3.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++; if (d1_ex !== 10'b0) begin failures++; $display("FAIL reset_ex got=%b exp=%b", d1_ex, 10'b0); end
        checks++; if (d1_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", d1_stall); end
        checks++; if (d1_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", d1_flush); end
        checks++; if (d3_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", d3_cnt); end
        $display("txn reset ex=%b stall=%b flush=%b", d1_ex, d1_stall, d1_flush);
        do_reset();
    endtask

    task automatic test_decode();
        logic [6:0] ops [7];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_SYS};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (d1_imm !== exp_imm(ops[i])) begin
                failures++; $display("FAIL dec_imm op=%b got=%0d exp=%0d", ops[i], d1_imm, exp_imm(ops[i]));
            end
            q1.push_back(exp_ctrl(ops[i], 1'b1));
            tick();
            exp_v = q1.pop_front();
            checks++;
            if (d1_ex !== exp_v) begin failures++; $display("FAIL dec_ex op=%b got=%b exp=%b", ops[i], d1_ex, exp_v); end
            $display("txn decode op=%b ex=%b imm=%0d", ops[i], d1_ex, d1_imm);
        end
        drive(OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        q1.push_back(10'b0);
        tick();
        exp_v = q1.pop_front();
        checks++;
        if (d1_ex !== exp_v) begin failures++; $display("FAIL dec_invalid got=%b exp=%b", d1_ex, exp_v); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        q1.push_back(exp_ctrl(OP_LOAD, 1'b1));
        q3.push_back(exp_ctrl(OP_LOAD, 1'b1));
        tick();
        exp_v = q1.pop_front(); checks++;
        if (d1_ex !== exp_v) begin failures++; $display("FAIL lu_lw_d1 got=%b exp=%b", d1_ex, exp_v); end
        exp_v = q3.pop_front(); checks++;
        if (d3_ex !== exp_v) begin failures++; $display("FAIL lu_lw_d3 got=%b exp=%b", d3_ex, exp_v); end
        // ADD x6,x5,x1 with LW x5 in EX
        drive(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++; if (d1_stall !== 1'b1) begin failures++; $display("FAIL lu_stall_d1 got=%b exp=1", d1_stall); end
        checks++; if (d3_stall !== 1'b1) begin failures++; $display("FAIL lu_stall_d3 got=%b exp=1", d3_stall); end
        q1.push_back(10'b0);
        q3.push_back(10'b0);
        tick();
        exp_v = q1.pop_front(); checks++;
        if (d1_ex !== exp_v) begin failures++; $display("FAIL lu_bub_d1 got=%b exp=%b", d1_ex, exp_v); end
        exp_v = q3.pop_front(); checks++;
        if (d3_ex !== exp_v) begin failures++; $display("FAIL lu_bub_d3 got=%b exp=%b", d3_ex, exp_v); end
        drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (d1_stall !== 1'b0) begin failures++; $display("FAIL lu_d1_stall t=%0d got=%b exp=0", t, d1_stall); end
            checks++;
            if (d3_stall !== (t < 2)) begin failures++; $display("FAIL lu_d3_stall t=%0d got=%b exp=%b", t, d3_stall, (t < 2)); end
            checks++;
            if (d1_cnt !== 16'd1) begin failures++; $display("FAIL lu_d1_cnt t=%0d got=%0d exp=1", t, d1_cnt); end
            checks++;
            if (d3_cnt !== 16'((t < 2) ? t + 1 : 3)) begin
                failures++; $display("FAIL lu_d3_cnt t=%0d got=%0d exp=%0d", t, d3_cnt, (t < 2) ? t + 1 : 3);
            end
            q1.push_back(exp_ctrl(OP_R, 1'b1));
            q3.push_back((t >= 2) ? exp_ctrl(OP_R, 1'b1) : 10'b0);
            tick();
            exp_v = q1.pop_front(); checks++;
            if (d1_ex !== exp_v) begin failures++; $display("FAIL lu_d1_ex t=%0d got=%b exp=%b", t, d1_ex, exp_v); end
            exp_v = q3.pop_front(); checks++;
            if (d3_ex !== exp_v) begin failures++; $display("FAIL lu_d3_ex t=%0d got=%b exp=%b", t, d3_ex, exp_v); end
            $display("txn load_use t=%0d d1_ex=%b d3_ex=%b d3_cnt=%0d", t, d1_ex, d3_ex, d3_cnt);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (d1_stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", d1_stall); end
        q1.push_back(exp_ctrl(OP_R, 1'b1));
        tick();
        exp_v = q1.pop_front(); checks++;
        if (d1_ex !== exp_v) begin failures++; $display("FAIL x0_ex got=%b exp=%b", d1_ex, exp_v); end
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_I, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++; if (d3_stall !== 1'b0) begin failures++; $display("FAIL irs2_stall got=%b exp=0", d3_stall); end
        q3.push_back(exp_ctrl(OP_I, 1'b1));
        tick();
        exp_v = q3.pop_front(); checks++;
        if (d3_ex !== exp_v) begin failures++; $display("FAIL irs2_ex got=%b exp=%b", d3_ex, exp_v); end
        checks++; if (d3_cnt !== 16'd0) begin failures++; $display("FAIL nostall_cnt got=%0d exp=0", d3_cnt); end
        $display("txn no_stall d1_ex=%b d3_ex=%b", d1_ex, d3_ex);
    endtask

    task automatic test_redirect();
        do_reset();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (d3_stall !== 1'b1) begin failures++; $display("FAIL red_pre_stall got=%b exp=1", d3_stall); end
        drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        checks++; if (d3_flush !== 1'b1) begin failures++; $display("FAIL red_flush got=%b exp=1", d3_flush); end
        checks++; if (d3_stall !== 1'b0) begin failures++; $display("FAIL red_stall got=%b exp=0", d3_stall); end
        q3.push_back(10'b0);
        tick();
        exp_v = q3.pop_front(); checks++;
        if (d3_ex !== exp_v) begin failures++; $display("FAIL red_bubble got=%b exp=%b", d3_ex, exp_v); end
        checks++; if (d3_cnt !== 16'd2) begin failures++; $display("FAIL red_cnt got=%0d exp=2", d3_cnt); end
        drive(OP_I, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (d3_stall !== 1'b0) begin failures++; $display("FAIL red_post_stall got=%b exp=0", d3_stall); end
        q3.push_back(exp_ctrl(OP_I, 1'b1));
        tick();
        exp_v = q3.pop_front(); checks++;
        if (d3_ex !== exp_v) begin failures++; $display("FAIL red_next got=%b exp=%b", d3_ex, exp_v); end
        $display("txn redirect d3_ex=%b d3_cnt=%0d", d3_ex, d3_cnt);
    endtask

    task automatic test_hold();
        do_reset();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (d3_stall !== 1'b1) begin failures++; $display("FAIL hold_stall k=%0d got=%b exp=1", k, d3_stall); end
            q3.push_back(10'b0);
            tick();
            exp_v = q3.pop_front(); checks++;
            if (d3_ex !== exp_v) begin failures++; $display("FAIL hold_ex k=%0d got=%b exp=%b", k, d3_ex, exp_v); end
            checks++;
            if (d3_cnt !== 16'd1) begin failures++; $display("FAIL hold_cnt k=%0d got=%0d exp=1", k, d3_cnt); end
            $display("txn hold k=%0d d3_ex=%b d3_cnt=%0d", k, d3_ex, d3_cnt);
        end
        drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (d3_stall !== (t < 2)) begin failures++; $display("FAIL resume_stall t=%0d got=%b exp=%b", t, d3_stall, (t < 2)); end
            q3.push_back((t == 2) ? exp_ctrl(OP_R, 1'b1) : 10'b0);
            tick();
            exp_v = q3.pop_front(); checks++;
            if (d3_ex !== exp_v) begin failures++; $display("FAIL resume_ex t=%0d got=%b exp=%b", t, d3_ex, exp_v); end
        end
        checks++; if (d3_cnt !== 16'd3) begin failures++; $display("FAIL resume_cnt got=%0d exp=3", d3_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(OP_R, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (ds_flush !== 1'b1) begin failures++; $display("FAIL sat_flush k=%0d got=%b exp=1", k, ds_flush); end
            tick();
            checks++;
            if (ds_cnt !== 2'((k < 3) ? k : 3)) begin
                failures++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, ds_cnt, (k < 3) ? k : 3);
            end
            checks++;
            if (d1_cnt !== 16'(k)) begin failures++; $display("FAIL wide_cnt k=%0d got=%0d exp=%0d", k, d1_cnt, k); end
            $display("txn saturate k=%0d ds_cnt=%0d d1_cnt=%0d", k, ds_cnt, d1_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (d3_stall !== 1'b1) begin failures++; $display("FAIL ar_pre_stall got=%b exp=1", d3_stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (d3_stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", d3_stall); end
        checks++; if (d3_cnt !== 16'd0) begin failures++; $display("FAIL ar_cnt got=%0d exp=0", d3_cnt); end
        checks++; if (d3_ex !== 10'b0) begin failures++; $display("FAIL ar_ex got=%b exp=0", d3_ex); end
        checks++; if (d3_flush !== 1'b0) begin failures++; $display("FAIL ar_flush got=%b exp=0", d3_flush); end
        $display("txn async_reset d3_ex=%b stall=%b cnt=%0d", d3_ex, d3_stall, d3_cnt);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_hold();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
